vx_mem_bus_arbiter: RTL and testbench

- Shares one downstream memory bus among NUM_INPUTS upstream requesters.
- Selects requesters round-robin and appends the winner's index to the request tag.
- Buffers the winning request in a 2-entry skid buffer and routes each response back by the index carried in its tag.
- Sits between per-unit memory ports (e.g. per-core cache ports) and a shared cache or memory port, using the standard memory-bus request/response field set.

---
 rtl/vx_mem_bus_arbiter_pkg.sv | 21 ++
 rtl/vx_mem_bus_arbiter_rr.sv | 60 ++++++
 rtl/vx_mem_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_vx_mem_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_bus_arbiter_pkg.sv
// vx_mem_bus_arbiter_pkg
// Shared constants and width helpers for the memory-bus arbiter slice.
// Request/response payload structs depend on module parameters, so they are
// declared inside the modules that own those parameters; this package only
// carries the default bus widths and the index-width helpers.
package vx_mem_bus_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH      = 32;
    localparam int MEM_REQ_FLAGS_WIDTH = 4;

    // Width of the requester index appended to tags (0 for a single requester).
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Width of an index signal that must physically exist (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_bus_arbiter_rr.sv
// vx_rr_arbiter
// Round-robin arbiter: grants the first valid requester at or after the
// priority pointer, wrapping modulo NUM_REQS. The pointer moves to the
// winner + 1 on every grant and holds otherwise.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   valid         per-requester request valid
//   enable        grants are issued only while enable is high
//   grant         one-hot grant (zero when nothing is granted)
//   index         binary index of the granted requester
//   grant_valid   a grant is being issued this cycle
//   prio          current priority pointer (exposed for observation)
module vx_rr_arbiter
    import vx_mem_bus_arbiter_pkg::*;
#(
    parameter int  NUM_REQS = 4,
    localparam int IDX_W    = idx_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] valid,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    index,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    prio
);

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_REQS - 1);
    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQS);

    logic [IDX_W:0] cand;

    // prio + k can reach 2*NUM_REQS-2, so the candidate carries one extra bit
    // and a single conditional subtract performs the wrap.
    always_comb begin
        grant       = '0;
        index       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = {1'b0, prio} + (IDX_W+1)'(k);
            if (cand > LAST) cand = cand - NREQ;
            if (enable && !grant_valid && valid[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                index       = cand[IDX_W-1:0];
            end
        end
        if (grant_valid) grant[index] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= '0;
        end else if (grant_valid) begin
            prio <= (index == LAST[IDX_W-1:0]) ? '0 : index + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vx_mem_bus_arbiter.sv
// vx_mem_bus_arbiter
// Shares one downstream memory bus among NUM_INPUTS requesters. A round-robin
// winner is pushed into a 2-entry FIFO skid buffer whose head drives out_req_*;
// the winner index is appended in the LSBs of the outgoing tag. Responses are
// routed back combinationally by the index found in the LSBs of out_rsp_tag.
// Optional macro VX_MEM_ARB_PERF_EN adds perf_req_count / perf_stall_count.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   in_req_*                   per-requester request fields, in_req_ready = grant
//   in_rsp_*                   per-requester response (data/tag broadcast)
//   out_req_*                  request toward the shared bus (registered)
//   out_rsp_*                  response from the shared bus
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; a valid request holds its fields stable until accepted.
module vx_mem_bus_arbiter
    import vx_mem_bus_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS  = 4,
    parameter int  DATA_SIZE   = 64,
    parameter int  FLAGS_WIDTH = MEM_REQ_FLAGS_WIDTH,
    parameter int  TAG_WIDTH   = 8,
    parameter int  ADDR_WIDTH  = MEM_ADDR_WIDTH - $clog2(DATA_SIZE),
    localparam int SEL_W       = sel_width(NUM_INPUTS),
    localparam int OUT_TAG_W   = TAG_WIDTH + SEL_W
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_INPUTS-1:0]                  in_req_valid,
    input  logic [NUM_INPUTS-1:0]                  in_req_rw,
    input  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0]  in_req_addr,
    input  logic [NUM_INPUTS-1:0][DATA_SIZE*8-1:0] in_req_data,
    input  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]   in_req_byteen,
    input  logic [NUM_INPUTS-1:0][FLAGS_WIDTH-1:0] in_req_flags,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]   in_req_tag,
    output logic [NUM_INPUTS-1:0]                  in_req_ready,
    output logic [NUM_INPUTS-1:0]                  in_rsp_valid,
    output logic [NUM_INPUTS-1:0][DATA_SIZE*8-1:0] in_rsp_data,
    output logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]   in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                  in_rsp_ready,
    output logic                                   out_req_valid,
    output logic                                   out_req_rw,
    output logic [ADDR_WIDTH-1:0]                  out_req_addr,
    output logic [DATA_SIZE*8-1:0]                 out_req_data,
    output logic [DATA_SIZE-1:0]                   out_req_byteen,
    output logic [FLAGS_WIDTH-1:0]                 out_req_flags,
    output logic [OUT_TAG_W-1:0]                   out_req_tag,
    input  logic                                   out_req_ready,
    input  logic                                   out_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]                 out_rsp_data,
    input  logic [OUT_TAG_W-1:0]                   out_rsp_tag,
    output logic                                   out_rsp_ready
`ifdef VX_MEM_ARB_PERF_EN
    ,
    output logic [63:0]                            perf_req_count,
    output logic [63:0]                            perf_stall_count
`endif
);

    localparam int SEL_WX = idx_width(NUM_INPUTS);

    typedef struct packed {
        logic                   rw;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_SIZE*8-1:0] data;
        logic [DATA_SIZE-1:0]   byteen;
        logic [FLAGS_WIDTH-1:0] flags;
        logic [OUT_TAG_W-1:0]   tag;
    } req_t;

    typedef struct packed {
        logic [DATA_SIZE*8-1:0] data;
        logic [OUT_TAG_W-1:0]   tag;
    } rsp_t;

    // ---------------- arbitration ----------------
    logic [NUM_INPUTS-1:0] arb_grant;
    logic [SEL_WX-1:0]     arb_idx;
    logic [SEL_WX-1:0]     arb_prio;
    logic                  arb_gv;
    logic                  arb_en;
    logic [1:0]            count;

    // reset_n gates the grant so nothing is accepted while reset is held.
    assign arb_en = reset_n && (count != 2'd2);

    vx_rr_arbiter #(
        .NUM_REQS (NUM_INPUTS)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid       (in_req_valid),
        .enable      (arb_en),
        .grant       (arb_grant),
        .index       (arb_idx),
        .grant_valid (arb_gv),
        .prio        (arb_prio)
    );

    assign in_req_ready = arb_grant;

    logic [OUT_TAG_W-1:0] win_tag;
    req_t                 win;

    always_comb begin
        win        = '0;
        win.rw     = in_req_rw[arb_idx];
        win.addr   = in_req_addr[arb_idx];
        win.data   = in_req_data[arb_idx];
        win.byteen = in_req_byteen[arb_idx];
        win.flags  = in_req_flags[arb_idx];
        win.tag    = win_tag;
    end

    // ---------------- 2-entry skid buffer ----------------
    req_t buf_q [2];
    req_t head;
    logic rd_ptr, wr_ptr;
    logic push, pop;

    assign push = arb_gv;
    assign pop  = out_req_valid && out_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: count qualifies every entry.
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= win;
    end

    assign head           = buf_q[rd_ptr];
    assign out_req_valid  = (count != 2'd0);
    assign out_req_rw     = head.rw;
    assign out_req_addr   = head.addr;
    assign out_req_data   = head.data;
    assign out_req_byteen = head.byteen;
    assign out_req_flags  = head.flags;
    assign out_req_tag    = head.tag;

    // ---------------- response routing ----------------
    rsp_t rsp;
    assign rsp = '{data: out_rsp_data, tag: out_rsp_tag};

    generate
        if (SEL_W > 0) begin : g_multi
            localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_INPUTS);
            logic [SEL_W-1:0] rsp_sel;
            logic             rsp_in_range;

            assign win_tag      = {in_req_tag[arb_idx], arb_idx};
            assign rsp_sel      = rsp.tag[SEL_W-1:0];
            assign rsp_in_range = ({1'b0, rsp_sel} < NUM_L);

            // An out-of-range index is dropped: acknowledged, never delivered.
            always_comb begin
                in_rsp_valid  = '0;
                out_rsp_ready = 1'b1;
                if (rsp_in_range) begin
                    in_rsp_valid[rsp_sel] = out_rsp_valid;
                    out_rsp_ready         = in_rsp_ready[rsp_sel];
                end
            end

            always_ff @(posedge clk) begin
                if (reset_n && out_rsp_valid)
                    assert (rsp_in_range)
                    else $warning("vx_mem_bus_arbiter: response index %0d out of range, dropped", rsp_sel);
            end

            always_comb begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    in_rsp_data[i] = rsp.data;
                    in_rsp_tag[i]  = rsp.tag[OUT_TAG_W-1:SEL_W];
                end
            end
        end else begin : g_single
            assign win_tag        = in_req_tag[0];
            assign in_rsp_valid   = out_rsp_valid;
            assign out_rsp_ready  = in_rsp_ready[0];
            assign in_rsp_data[0] = rsp.data;
            assign in_rsp_tag[0]  = rsp.tag;
        end
    endgenerate

    // ---------------- optional performance counters ----------------
`ifdef VX_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_req_count   <= 64'd0;
            perf_stall_count <= 64'd0;
        end else begin
            if (pop)                            perf_req_count   <= perf_req_count + 64'd1;
            if (out_req_valid && !out_req_ready) perf_stall_count <= perf_stall_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_bus_arbiter.sv
// tb_vx_mem_bus_arbiter
// Bench for vx_mem_bus_arbiter: a 4-input instance exercises arbitration,
// backpressure, reset and response routing; a 3-input instance covers the
// out-of-range response drop. Expected requests and responses are queued by
// the driver and popped by negedge monitors when the DUT presents them.
module tb_vx_mem_bus_arbiter;

    localparam int N   = 4;
    localparam int N3  = 3;
    localparam int DS  = 8;
    localparam int DW  = DS * 8;
    localparam int FW  = 4;
    localparam int TW  = 8;
    localparam int AW  = 29;
    localparam int OTW = TW + 2;
    localparam int RW  = 1 + AW + DW + DS + FW + OTW;
    localparam int PW  = N + TW + 1 + DW;
    localparam int P3W = N3 + TW + 1;

    logic clk, reset_n;

    // 4-input instance
    logic [N-1:0]         in_req_valid, in_req_rw, in_req_ready;
    logic [N-1:0][AW-1:0] in_req_addr;
    logic [N-1:0][DW-1:0] in_req_data;
    logic [N-1:0][DS-1:0] in_req_byteen;
    logic [N-1:0][FW-1:0] in_req_flags;
    logic [N-1:0][TW-1:0] in_req_tag;
    logic [N-1:0]         in_rsp_valid, in_rsp_ready;
    logic [N-1:0][DW-1:0] in_rsp_data;
    logic [N-1:0][TW-1:0] in_rsp_tag;
    logic                 out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]        out_req_addr;
    logic [DW-1:0]        out_req_data;
    logic [DS-1:0]        out_req_byteen;
    logic [FW-1:0]        out_req_flags;
    logic [OTW-1:0]       out_req_tag;
    logic                 out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]        out_rsp_data;
    logic [OTW-1:0]       out_rsp_tag;

    // 3-input instance (response path only; request side idle)
    logic [N3-1:0]         r3_in_req_ready, r3_in_rsp_valid, r3_in_rsp_ready;
    logic [N3-1:0][DW-1:0] r3_in_rsp_data;
    logic [N3-1:0][TW-1:0] r3_in_rsp_tag;
    logic                  r3_out_req_valid, r3_out_req_rw;
    logic [AW-1:0]         r3_out_req_addr;
    logic [DW-1:0]         r3_out_req_data;
    logic [DS-1:0]         r3_out_req_byteen;
    logic [FW-1:0]         r3_out_req_flags;
    logic [OTW-1:0]        r3_out_req_tag;
    logic                  r3_out_rsp_valid, r3_out_rsp_ready;
    logic [OTW-1:0]        r3_out_rsp_tag;

`ifdef VX_MEM_ARB_PERF_EN
    logic [63:0] perf_req_count, perf_stall_count, r3_perf_req, r3_perf_stall;
    longint      m_req, m_stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0]  exp_q  [$];
    logic [PW-1:0]  rsp_q  [$];
    logic [P3W-1:0] rsp3_q [$];

    vx_mem_bus_arbiter #(
        .NUM_INPUTS(N), .DATA_SIZE(DS), .FLAGS_WIDTH(FW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_flags(in_req_flags),
        .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_flags(out_req_flags),
        .out_req_tag(out_req_tag), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready)
`ifdef VX_MEM_ARB_PERF_EN
        , .perf_req_count(perf_req_count), .perf_stall_count(perf_stall_count)
`endif
    );

    vx_mem_bus_arbiter #(
        .NUM_INPUTS(N3), .DATA_SIZE(DS), .FLAGS_WIDTH(FW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)
    ) dut3 (
        .clk(clk), .reset_n(reset_n),
        .in_req_valid('0), .in_req_rw('0), .in_req_addr('0),
        .in_req_data('0), .in_req_byteen('0), .in_req_flags('0),
        .in_req_tag('0), .in_req_ready(r3_in_req_ready),
        .in_rsp_valid(r3_in_rsp_valid), .in_rsp_data(r3_in_rsp_data), .in_rsp_tag(r3_in_rsp_tag),
        .in_rsp_ready(r3_in_rsp_ready),
        .out_req_valid(r3_out_req_valid), .out_req_rw(r3_out_req_rw), .out_req_addr(r3_out_req_addr),
        .out_req_data(r3_out_req_data), .out_req_byteen(r3_out_req_byteen), .out_req_flags(r3_out_req_flags),
        .out_req_tag(r3_out_req_tag), .out_req_ready(1'b0),
        .out_rsp_valid(r3_out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(r3_out_rsp_tag),
        .out_rsp_ready(r3_out_rsp_ready)
`ifdef VX_MEM_ARB_PERF_EN
        , .perf_req_count(r3_perf_req), .perf_stall_count(r3_perf_stall)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-requester field values ----------------
    function automatic logic f_rw(input int i);             return i[0];                         endfunction
    function automatic logic [AW-1:0] f_addr(input int i);  return AW'(32'h100 + i);             endfunction
    function automatic logic [DW-1:0] f_data(input int i);  return 64'h1111_1111_1111_1111 * 64'(i + 1); endfunction
    function automatic logic [DS-1:0] f_be(input int i);    return 8'hF0 | 8'(i);               endfunction
    function automatic logic [FW-1:0] f_flags(input int i); return FW'(i + 1);                   endfunction
    function automatic logic [TW-1:0] f_tag(input int i);   return 8'h30 + 8'(i);                endfunction

    // Expected shared-bus request for requester i: index appended in tag LSBs.
    function automatic logic [RW-1:0] req_word(input int i);
        return {f_rw(i), f_addr(i), f_data(i), f_be(i), f_flags(i), f_tag(i), 2'(i)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic rsp4(input logic [OTW-1:0] tag, input logic [N-1:0] rdy, input logic [PW-1:0] exp);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = tag;
        in_rsp_ready  = rdy;
        rsp_q.push_back(exp);
        idle(1);
        out_rsp_valid = 1'b0;
    endtask

    task automatic rsp3(input logic [OTW-1:0] tag, input logic [N3-1:0] rdy, input logic [P3W-1:0] exp);
        r3_out_rsp_valid = 1'b1;
        r3_out_rsp_tag   = tag;
        r3_in_rsp_ready  = rdy;
        rsp3_q.push_back(exp);
        idle(1);
        r3_out_rsp_valid = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (out_req_valid && out_req_ready) begin
            if (exp_q.size() == 0)
                check("req_unexpected", 128'(out_req_tag), 128'h3FF_FFFF);
            else
                check("req_out", 128'({out_req_rw, out_req_addr, out_req_data, out_req_byteen,
                                       out_req_flags, out_req_tag}), 128'(exp_q.pop_front()));
        end
        if (out_rsp_valid) begin
            if (rsp_q.size() == 0)
                check("rsp_unexpected", 128'(in_rsp_valid), 128'hFFFF);
            else
                check("rsp_route", 128'({in_rsp_valid, in_rsp_tag[0], out_rsp_ready, in_rsp_data[N-1]}),
                      128'(rsp_q.pop_front()));
        end
        if (r3_out_rsp_valid) begin
            if (rsp3_q.size() == 0)
                check("rsp3_unexpected", 128'(r3_in_rsp_valid), 128'hFFFF);
            else
                check("rsp3_route", 128'({r3_in_rsp_valid, r3_in_rsp_tag[0], r3_out_rsp_ready}),
                      128'(rsp3_q.pop_front()));
        end
    end

`ifdef VX_MEM_ARB_PERF_EN
    always @(negedge clk) begin
        if (!reset_n) begin
            m_req   = 0;
            m_stall = 0;
        end else begin
            if (out_req_valid && out_req_ready)  m_req++;
            if (out_req_valid && !out_req_ready) m_stall++;
        end
    end
`endif

    // ---------------- driver ----------------
    int rot [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset_n          = 1'b0;
        in_req_valid     = '0;
        out_req_ready    = 1'b0;
        out_rsp_valid    = 1'b0;
        out_rsp_data     = 64'hDEAD_BEEF_0123_4567;
        out_rsp_tag      = '0;
        in_rsp_ready     = '0;
        r3_out_rsp_valid = 1'b0;
        r3_out_rsp_tag   = '0;
        r3_in_rsp_ready  = '0;
        for (int i = 0; i < N; i++) begin
            in_req_rw[i]     = f_rw(i);
            in_req_addr[i]   = f_addr(i);
            in_req_data[i]   = f_data(i);
            in_req_byteen[i] = f_be(i);
            in_req_flags[i]  = f_flags(i);
            in_req_tag[i]    = f_tag(i);
        end

        // Reset state: requests pending but nothing granted, bus idle.
        in_req_valid = 4'hF;
        @(negedge clk);
        check("rst_in_ready", 128'(in_req_ready), 128'h0);
        check("rst_out_valid", 128'(out_req_valid), 128'h0);
        @(posedge clk);
        #1;
        in_req_valid = '0;
        reset_n      = 1'b1;
        idle(1);

        // Fair rotation, one grant per cycle.
        out_req_ready = 1'b1;
        in_req_valid  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rot_grant", 128'(in_req_ready), 128'(4'b0001 << rot[k]));
            exp_q.push_back(req_word(rot[k]));
            @(posedge clk);
            #1;
        end
        in_req_valid = '0;
        idle(3);
        check("rot_drain", 128'(exp_q.size()), 128'h0);

        // Backpressure: two accepted into the buffer, then stalled.
        pulse_reset();
        out_req_ready = 1'b0;
        in_req_valid  = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_grant", 128'(in_req_ready), (k == 0) ? 128'h1 : (k == 1) ? 128'h2 : 128'h0);
            if (k < 2) exp_q.push_back(req_word(k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_head", 128'({out_req_valid, out_req_rw, out_req_addr, out_req_data, out_req_byteen,
                               out_req_flags, out_req_tag}), 128'({1'b1, req_word(0)}));
        @(posedge clk);
        #1;
        in_req_valid  = '0;
        out_req_ready = 1'b1;
        idle(3);
        check("bp_drain", 128'(exp_q.size()), 128'h0);

        // Response routing (4 inputs).
        rsp4({8'hA5, 2'd2}, 4'b1111, {4'b0100, 8'hA5, 1'b1, 64'hDEAD_BEEF_0123_4567});
        rsp4({8'hA5, 2'd2}, 4'b1011, {4'b0100, 8'hA5, 1'b0, 64'hDEAD_BEEF_0123_4567});
        rsp4({8'h3C, 2'd0}, 4'b0001, {4'b0001, 8'h3C, 1'b1, 64'hDEAD_BEEF_0123_4567});
        rsp4({8'h5A, 2'd3}, 4'b0111, {4'b1000, 8'h5A, 1'b0, 64'hDEAD_BEEF_0123_4567});

        // Non-power-of-two: index 3 is dropped and acknowledged.
        rsp3({8'h77, 2'd3}, 3'b000, {3'b000, 8'h77, 1'b1});
        rsp3({8'h12, 2'd1}, 3'b010, {3'b010, 8'h12, 1'b1});
        rsp3({8'h12, 2'd1}, 3'b101, {3'b010, 8'h12, 1'b0});

        // Reset mid-traffic: buffered requests are discarded.
        pulse_reset();
        out_req_ready = 1'b0;
        in_req_valid  = 4'b1100;
        idle(2);
        @(negedge clk);
        check("mid_full", 128'({out_req_valid, in_req_ready}), 128'({1'b1, 4'b0000}));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 128'({out_req_valid, in_req_ready}), 128'h0);
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        in_req_valid = 4'b1010;
        @(negedge clk);
        check("mid_first_grant", 128'(in_req_ready), 128'h2);
        exp_q.push_back(req_word(1));
        @(posedge clk);
        #1;
        in_req_valid  = '0;
        out_req_ready = 1'b1;
        idle(3);

`ifdef VX_MEM_ARB_PERF_EN
        // Traffic with stalls for the counters.
        out_req_ready = 1'b0;
        in_req_valid  = 4'b0001;
        @(negedge clk);
        exp_q.push_back(req_word(0));
        @(posedge clk);
        #1;
        in_req_valid = '0;
        idle(3);
        out_req_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("perf_req", 128'(perf_req_count), 128'(m_req));
        check("perf_stall", 128'(perf_stall_count), 128'(m_stall));
        @(posedge clk);
        #1;
`endif

        check("final_req_q", 128'(exp_q.size()), 128'h0);
        check("final_rsp_q", 128'(rsp_q.size() + rsp3_q.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
